// File: rtl/muldiv_sequencer_pkg.sv
// Shared op codes, FSM states and defaults for the
// multi-cycle M-extension sequencer.
package muldiv_sequencer_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_MULH = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_REM  = 4'd11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic op_legal(input logic [3:0] o);
    return o[3:2] == 2'b10;
  endfunction

  function automatic logic op_div(input logic [3:0] o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One iteration of shift-add multiply or restoring divide,
// sharing a single 65-bit adder between the two.
module muldiv_sequencer_step #(
  parameter int XLEN = 64
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN-1:0] hi, lo;
  logic [XLEN:0]   x, y, sum;
  logic            cin, borrow;

  assign {hi, lo} = acc_i;

  always_comb begin
    if (div_i) begin
      x   = {hi, lo[XLEN-1]};
      y   = ~{1'b0, opnd_i};
      cin = 1'b1;
    end else begin
      x   = {1'b0, hi};
      y   = lo[0] ? {1'b0, opnd_i} : '0;
      cin = 1'b0;
    end
    sum = x + y + {{XLEN{1'b0}}, cin};
    // remainder < divisor, so bit XLEN of the difference is the borrow
    borrow = sum[XLEN];
    if (div_i)
      acc_o = {borrow ? x[XLEN-1:0] : sum[XLEN-1:0],
               lo[XLEN-2:0], ~borrow};
    else
      acc_o = {sum, lo[XLEN-1:1]};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mul/mulh/div/rem sequencer: accept, prep,
// XLEN-step calc, sign fix, one-cycle valid.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d, fix_res;
  logic [XLEN-1:0]   maga, magb;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sa, sb, is_div, accept;

  assign sa     = a_q[XLEN-1];
  assign sb     = b_q[XLEN-1];
  assign maga   = sa ? -a_q : a_q;
  assign magb   = sb ? -b_q : b_q;
  assign is_div = op_div(op_q);

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy   = (state_q == PREP) || (state_q == CALC) ||
                  (state_q == FIX);
  assign valid  = (state_q == DONE);
  assign result = res_q;
  assign accept = start && ready && !flush;

  muldiv_sequencer_step #(.XLEN(XLEN)) u_step (
    .div_i  (is_div),
    .acc_i  (acc_q),
    .opnd_i (is_div ? magb : maga),
    .acc_o  (acc_step)
  );

  always_comb begin
    prod    = (sa ^ sb) ? -acc_q : acc_q;
    fix_res = '0;
    unique case (1'b1)
      op_q == OP_MUL:  fix_res = prod[XLEN-1:0];
      op_q == OP_MULH: fix_res = prod[2*XLEN-1:XLEN];
      op_q == OP_DIV:  fix_res = (sa ^ sb) ? -acc_q[XLEN-1:0]
                                           : acc_q[XLEN-1:0];
      op_q == OP_REM:  fix_res = sa ? -acc_q[2*XLEN-1:XLEN]
                                    : acc_q[2*XLEN-1:XLEN];
      default:         fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: ;
        DONE: state_d = IDLE;
        PREP: begin
          state_d = DONE;
          if (!op_legal(op_q)) begin
            res_d = '0;
          end else if (is_div && b_q == '0) begin
            res_d = (op_q == OP_DIV) ? '1 : a_q;
          end else if (is_div && a_q == MIN_INT && b_q == '1) begin
            res_d = (op_q == OP_DIV) ? MIN_INT : '0;
          end else begin
            acc_d   = {{XLEN{1'b0}}, is_div ? maga : magb};
            cnt_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) state_d = FIX;
        end
        FIX: begin
          res_d   = fix_res;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
      if (accept) begin
        op_d    = op;
        a_d     = a;
        b_d     = b;
        state_d = PREP;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency,
// back-to-back issue, flush and async reset.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINI = 64'h8000_0000_0000_0000;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        ready, busy, valid;
  logic [63:0] result;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  muldiv_sequencer #(.XLEN(64)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .ready   (ready),
    .busy    (busy),
    .valid   (valid),
    .result  (result)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [63:0] x,
                       input logic [63:0] y);
    @(negedge CLK);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge CLK);
    #1;
    start = 1'b0;
    op = 4'hf;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat, output int nb,
                            output int nr);
    lat = 0;
    nb = 0;
    nr = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge CLK);
      if (valid) begin
        lat = k;
        break;
      end
      if (busy) nb++;
      if (!ready) nr++;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] o,
                     input logic [63:0] x, input logic [63:0] y,
                     input logic [63:0] exp, input int elat);
    int lat, nb, nr;
    issue(o, x, y);
    wait_valid(lat, nb, nr);
    check({tag, ".lat"}, 64'(lat), 64'(elat));
    check({tag, ".res"}, result, exp);
    check({tag, ".busy"}, 64'(nb), 64'(elat - 1));
    check({tag, ".nrdy"}, 64'(nr), 64'(elat - 1));
  endtask

  initial begin
    int lat, nb, nr, nv;
    repeat (2) @(negedge CLK);
    check("rst.valid", 64'(valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.ready", 64'(ready), 64'd1);
    check("rst.res", result, 64'd0);
    RESET_N = 1'b1;

    run("mul6x5", OP_MUL, 64'd6, 64'd5, 64'd30, 67);
    run("mulh_min2", OP_MULH, MINI, 64'd2, ONES, 67);
    run("mulh_m1m1", OP_MULH, ONES, ONES, 64'd0, 67);
    run("mul_m1m1", OP_MUL, ONES, ONES, 64'd1, 67);
    run("div66_11", OP_DIV, 64'd66, 64'd11, 64'd6, 67);
    run("rem62_3", OP_REM, 64'd62, 64'd3, 64'd2, 67);
    run("div_m7_2", OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 67);
    run("rem_m7_2", OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
        ONES, 67);
    run("div7_m2", OP_DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
        64'hFFFF_FFFF_FFFF_FFFD, 67);
    run("rem7_m2", OP_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
        64'd1, 67);
    run("div5_0", OP_DIV, 64'd5, 64'd0, ONES, 2);
    run("rem5_0", OP_REM, 64'd5, 64'd0, 64'd5, 2);
    run("div_ovf", OP_DIV, MINI, ONES, MINI, 2);
    run("rem_ovf", OP_REM, MINI, ONES, 64'd0, 2);
    run("illegal", 4'd3, 64'd9, 64'd9, 64'd0, 2);

    issue(OP_MUL, 64'd6, 64'd5);
    wait_valid(lat, nb, nr);
    check("b2b.lat1", 64'(lat), 64'd67);
    check("b2b.res1", result, 64'd30);
    start = 1'b1;
    op = OP_MUL;
    a = 64'd7;
    b = 64'd3;
    @(posedge CLK);
    #1;
    start = 1'b0;
    nv = 0;
    lat = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge CLK);
      if (valid) begin
        nv++;
        if (lat == 0) lat = k;
      end
    end
    check("b2b.lat2", 64'(lat), 64'd67);
    check("b2b.nvalid", 64'(nv), 64'd1);
    check("b2b.res2", result, 64'd21);

    issue(OP_DIV, 64'd100, 64'd7);
    nv = 0;
    for (int k = 1; k <= 29; k++) begin
      @(negedge CLK);
      if (valid) nv++;
    end
    @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge CLK);
      if (k == 1) check("flush.ready", 64'(ready), 64'd1);
      if (valid) nv++;
    end
    check("flush.nvalid", 64'(nv), 64'd0);
    check("flush.res", result, 64'd21);
    run("postflush", OP_MUL, 64'd6, 64'd5, 64'd30, 67);

    @(negedge CLK);
    start = 1'b1;
    flush = 1'b1;
    op = OP_MUL;
    @(posedge CLK);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge CLK);
    check("flushwins.busy", 64'(busy), 64'd0);

    issue(OP_MULH, 64'd3, 64'd5);
    repeat (39) @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("arst.valid", 64'(valid), 64'd0);
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.res", result, 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    nv = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge CLK);
      if (valid) nv++;
    end
    check("arst.nvalid", 64'(nv), 64'd0);
    run("postrst", OP_MUL, 64'd12, 64'd12, 64'd144, 67);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the M-extension ALU ops (mul, mulh, div, rem) in the RV64IM core.
- Replaces single-cycle multiply/divide with one 64-iteration shift-add / restoring-divide engine.
- The execute stage issues an op, stalls on busy, and writes back on valid.
- Op codes match the ALU encoding: 8 = mul, 9 = mulh, 10 = div, 11 = rem.

Parameters:
XLEN, 64, operand/result width; iteration count equals XLEN.

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET_N  in  1  asynchronous active-low reset
start  in  1  issue request; accepted when start & ready & !flush
op  in  4  ALU op code; only 8..11 legal; others accepted, result 0, short path
a  in  XLEN  operand rs1 (dividend / multiplicand)
b  in  XLEN  operand rs2 (divisor / multiplier)
flush  in  1  synchronous abort of in-flight op
ready  out  1  state==IDLE or state==DONE
busy  out  1  state in {PREP, CALC, FIX}
valid  out  1  one-cycle pulse, result is valid
result  out  XLEN  result; held from DONE until the next accept

Behaviour:
- Reset (async, RESET_N=0): state=IDLE, valid=0, result=0, busy=0, counter=0, internal registers 0. Takes effect mid-operation too; the op is discarded with no valid.
- Accept: at edge e0 with start&ready&!flush, latch op, a, b, sign bits and magnitudes. Next state is PREP.
- PREP (cycle 1):
  - div/rem with b==0: result = all-ones (div) or a (rem). Next state is DONE.
  - div/rem with a==MIN_INT and b==-1: result = MIN_INT (div) or 0 (rem). Next state is DONE.
  - Illegal op: result = 0. Next state is DONE.
  - Otherwise: clear the 2*XLEN accumulator and counter. Next state is CALC.
- CALC (cycles 2..XLEN+1): one bit per cycle, counter 0..XLEN-1. Exit to FIX when counter==XLEN-1.
  - mul/mulh: unsigned shift-add of magnitudes into the 128-bit accumulator.
  - div/rem: restoring division on magnitudes using a 65-bit subtract. Quotient bit = no borrow.
- FIX (cycle XLEN+2): apply signs and register result.
  - mul: low XLEN bits of the product, sign-corrected by 128-bit two's-complement negation when sign(a)^sign(b).
  - mulh: high XLEN bits of the signed x signed product, same negation.
  - div: quotient, negated if sign(a)^sign(b). Truncates toward zero.
  - rem: remainder, negated if sign(a).
- DONE (cycle XLEN+3 normal, cycle 2 short path):
  - valid=1 for exactly one cycle.
  - ready=1: a new start accepted here goes to PREP at the next edge (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Latency: valid at cycle 67 after e0 for XLEN=64; cycle 2 on the short path.
- flush:
  - In any state, next state is IDLE, valid stays 0, result is unchanged.
  - flush with start in the same cycle: flush wins, start is ignored.
  - flush in DONE does not suppress that cycle's valid.
- start while busy is ignored. The requester must hold it until ready.
- Operands are sampled only at accept; later changes to a/b/op have no effect.

Decomposition:
- Shared header muldiv_defs.vh holds:
  - op code localparams OP_MUL=8, OP_MULH=9, OP_DIV=10, OP_REM=11, shared with the ALU;
  - state encodings IDLE, PREP, CALC, FIX, DONE (3-bit);
  - the XLEN default.
- One natural sub-module: muldiv_step, a combinational single iteration covering the 65-bit add/sub and shift, selected by a mul/div flag. The FSM, counter and sign fixing stay in muldiv_sequencer.

Test Plan:
- mul a=6, b=5 issued at e0 -> valid pulse at cycle 67, result=30, busy high cycles 1..66, ready=0 cycles 1..66.
- mulh a=0x8000000000000000, b=2 -> 0xFFFFFFFFFFFFFFFF; mulh a=-1, b=-1 -> 0; mul a=-1, b=-1 -> 1.
- div 66/11 -> 6; rem 62/3 -> 2; div -7/2 -> -3 (0xFFFFFFFFFFFFFFFD); rem -7/2 -> -1.
- div 5/0 -> 0xFFFFFFFFFFFFFFFF with valid at cycle 2; rem 5/0 -> 5; div MIN_INT/-1 -> MIN_INT; rem MIN_INT/-1 -> 0, all on the short path.
- Back-to-back: second start held high during DONE of a mul -> accepted that cycle; second result valid 67 cycles later, no lost or duplicate valid.
- flush at cycle 30 of a div -> no valid, ready=1 next cycle, subsequent mul 6*5 -> 30. RESET_N low at cycle 40 of a mulh -> immediate IDLE, valid=0, result=0.
